// File: rtl/conv1d_cfu_pkg.sv
// Shared definitions for the conv1d CFU command interface: command codes, sequencer states, kernel size.
package conv1d_cfu_pkg;

  localparam int KERNEL_LENGTH = 8;

  localparam logic [6:0] CMD_WR_IN    = 7'd1;
  localparam logic [6:0] CMD_WR_FLT   = 7'd2;
  localparam logic [6:0] CMD_IN_OFF   = 7'd3;
  localparam logic [6:0] CMD_DEPTH    = 7'd5;
  localparam logic [6:0] CMD_START    = 7'd6;
  localparam logic [6:0] CMD_GET_ACC  = 7'd7;
  localparam logic [6:0] CMD_START_X  = 7'd8;
  localparam logic [6:0] CMD_DONE     = 7'd9;
  localparam logic [6:0] CMD_BIAS     = 7'd10;
  localparam logic [6:0] CMD_MULT     = 7'd11;
  localparam logic [6:0] CMD_SHIFT    = 7'd12;
  localparam logic [6:0] CMD_ACT_MIN  = 7'd13;
  localparam logic [6:0] CMD_ACT_MAX  = 7'd14;
  localparam logic [6:0] CMD_OUT_OFF  = 7'd15;
  localparam logic [6:0] CMD_RW_WIDTH = 7'd16;

  typedef enum logic [2:0] {
    S_IDLE, S_PARAMS, S_LOAD_F, S_LOAD_I, S_START, S_POLL, S_READ, S_OUT
  } seq_state_t;

endpackage

// File: rtl/conv1d_cfu_loader.sv
// Word counter and byte-address generator for the buffer-load stream; reused for filter and input loads.
module conv1d_cfu_loader (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        active,
  input  logic        ld_valid,
  input  logic [31:0] words,
  output logic        ld_ready,
  output logic        fire,
  output logic        last,
  output logic [31:0] addr
);
  logic [31:0] k;

  assign ld_ready = active;
  assign fire     = active & ld_valid;
  assign last     = fire && (k == words - 32'd1);
  assign addr     = {k[29:0], 2'b00};

  // Counter self-clears on the final word so the next load restarts at address 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                k <= '0;
    else if (clear || last) k <= '0;
    else if (fire)          k <= k + 32'd1;
  end
endmodule

// File: rtl/conv1d_cfu_sequencer.sv
// Drives the conv1d CFU through params, buffer loads, compute, done-poll and result read.
// CFU_SEQ_TIMEOUT_EN: abort polling with an err pulse after POLL_TIMEOUT cycles without done.
module conv1d_cfu_sequencer
  import conv1d_cfu_pkg::*;
#(
  parameter int MAX_DEPTH = 128
`ifdef CFU_SEQ_TIMEOUT_EN
  , parameter int POLL_TIMEOUT = 4096
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      cfg_depth,
  input  logic [31:0]      cfg_in_off,
  input  logic [31:0]      cfg_start_x,
  input  logic [5:0][31:0] cfg_quant,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [31:0]      ld_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic             busy,
  output logic             err,
  output logic             cfu_en,
  output logic [6:0]       cfu_cmd,
  output logic [31:0]      cfu_inp0,
  output logic [31:0]      cfu_inp1,
  input  logic [31:0]      cfu_ret
);
  seq_state_t      state;
  logic [31:0]     depth_q, in_off_q, start_x_q, words, ld_addr;
  logic [5:0][31:0] quant_q;
  logic [3:0]      pidx;
  logic [2:0]      qidx;
  logic [1:0]      vld_pipe;
  logic            rd_ph, ld_fire, ld_last;
  logic [6:0]      p_cmd;
  logic [31:0]     p_val;
`ifdef CFU_SEQ_TIMEOUT_EN
  logic [31:0]     poll_cnt;
`endif

  assign busy  = (state != S_IDLE);
  assign words = 32'((depth_q * 32'(KERNEL_LENGTH)) >> 2);
  // pidx 4..9 map onto quant slots 0..5 through 3-bit wraparound.
  assign qidx  = pidx[2:0] - 3'd4;

  always_comb begin
    p_cmd = CMD_RW_WIDTH;
    p_val = 32'd4;
    case (pidx)
      4'd0: ;
      4'd1: begin p_cmd = CMD_IN_OFF;  p_val = in_off_q;  end
      4'd2: begin p_cmd = CMD_DEPTH;   p_val = depth_q;   end
      4'd3: begin p_cmd = CMD_START_X; p_val = start_x_q; end
      default: begin p_cmd = CMD_BIAS + {4'd0, qidx}; p_val = quant_q[qidx]; end
    endcase
  end

  conv1d_cfu_loader u_loader (
    .clk      (clk),
    .rst      (rst),
    .clear    (state == S_IDLE),
    .active   (state == S_LOAD_F || state == S_LOAD_I),
    .ld_valid (ld_valid),
    .words    (words),
    .ld_ready (ld_ready),
    .fire     (ld_fire),
    .last     (ld_last),
    .addr     (ld_addr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      depth_q <= '0; in_off_q <= '0; start_x_q <= '0; quant_q <= '0;
      pidx <= '0; vld_pipe <= '0; rd_ph <= 1'b0;
      res_valid <= 1'b0; res_data <= '0; err <= 1'b0;
      cfu_en <= 1'b0; cfu_cmd <= '0; cfu_inp0 <= '0; cfu_inp1 <= '0;
`ifdef CFU_SEQ_TIMEOUT_EN
      poll_cnt <= '0;
`endif
    end else begin
      err <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          if (cfg_depth > 32'(MAX_DEPTH)) err <= 1'b1;
          else begin
            depth_q <= cfg_depth; in_off_q <= cfg_in_off;
            start_x_q <= cfg_start_x; quant_q <= cfg_quant;
            pidx <= '0;
            state <= S_PARAMS;
          end
        end
        S_PARAMS: begin
          cfu_en <= 1'b1; cfu_cmd <= p_cmd; cfu_inp0 <= '0; cfu_inp1 <= p_val;
          pidx <= pidx + 4'd1;
          if (pidx == 4'd9) state <= (words == '0) ? S_START : S_LOAD_F;
        end
        S_LOAD_F, S_LOAD_I: begin
          // Stall cycles issue the side-effect-free done poll.
          if (ld_fire) begin
            cfu_cmd  <= (state == S_LOAD_F) ? CMD_WR_FLT : CMD_WR_IN;
            cfu_inp0 <= ld_addr;
            cfu_inp1 <= ld_data;
          end else begin
            cfu_cmd <= CMD_DONE; cfu_inp0 <= '0; cfu_inp1 <= '0;
          end
          if (ld_last) state <= (state == S_LOAD_F) ? S_LOAD_I : S_START;
        end
        S_START: begin
          cfu_cmd <= CMD_START; cfu_inp0 <= '0; cfu_inp1 <= '0;
          vld_pipe <= '0;
`ifdef CFU_SEQ_TIMEOUT_EN
          poll_cnt <= '0;
`endif
          state <= S_POLL;
        end
        S_POLL: begin
          // ret is meaningful for polls only once the cmd 6 response has passed.
          cfu_cmd <= CMD_DONE;
          vld_pipe <= {vld_pipe[0], 1'b1};
          if (vld_pipe[1] && cfu_ret[0]) begin
            cfu_cmd <= CMD_GET_ACC; rd_ph <= 1'b0; state <= S_READ;
          end
`ifdef CFU_SEQ_TIMEOUT_EN
          else if (poll_cnt == 32'(POLL_TIMEOUT - 1)) begin
            err <= 1'b1; cfu_en <= 1'b0; cfu_cmd <= '0; state <= S_IDLE;
          end else poll_cnt <= poll_cnt + 32'd1;
`endif
        end
        S_READ: begin
          cfu_cmd <= CMD_DONE;
          rd_ph <= 1'b1;
          if (rd_ph) begin
            res_data <= cfu_ret; res_valid <= 1'b1;
            cfu_en <= 1'b0; cfu_cmd <= '0;
            state <= S_OUT;
          end
        end
        S_OUT: if (res_ready) begin
          res_valid <= 1'b0; state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv1d_cfu_sequencer.sv
// Directed bench: sequencer paired with a behavioural conv1d CFU responder.
module tb_conv1d_cfu_sequencer;
  import conv1d_cfu_pkg::*;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [31:0] cfg_depth = '0, cfg_in_off = '0, cfg_start_x = '0;
  logic [5:0][31:0] cfg_quant = '0;
  logic ld_valid = 1'b0, ld_ready, res_valid, res_ready = 1'b0, busy, err, cfu_en;
  logic [31:0] ld_data = '0, res_data, cfu_inp0, cfu_inp1, cfu_ret = '0;
  logic [6:0] cfu_cmd;

  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  conv1d_cfu_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .cfg_depth(cfg_depth), .cfg_in_off(cfg_in_off),
    .cfg_start_x(cfg_start_x), .cfg_quant(cfg_quant), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .err(err), .cfu_en(cfu_en), .cfu_cmd(cfu_cmd), .cfu_inp0(cfu_inp0),
    .cfu_inp1(cfu_inp1), .cfu_ret(cfu_ret)
  );

  // ---------------- responder model ----------------
  logic [7:0] fbuf [0:1023];
  logic [7:0] ibuf [0:1023];
  logic [31:0] r_in_off = '0, r_depth = '0;
  logic [5:0][31:0] r_q = '0;
  int done_cnt = 0, cyc = 0, t6 = 0, t7 = 0;
  bit started = 1'b0, force_busy = 1'b0;
  logic [70:0] log_q[$];

  function automatic logic [31:0] cfu_result();
    longint acc = 0, v;
    for (int j = 0; j < 8 * int'(r_depth); j++)
      acc += longint'($signed(fbuf[j])) * (longint'($signed(ibuf[j])) + longint'($signed(r_in_off)));
    v = (acc + longint'($signed(r_q[0]))) * longint'($signed(r_q[1]));
    v = v >>> r_q[2];
    v = v + longint'($signed(r_q[5]));
    if (v < longint'($signed(r_q[3]))) v = longint'($signed(r_q[3]));
    if (v > longint'($signed(r_q[4]))) v = longint'($signed(r_q[4]));
    return v[31:0];
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    cfu_ret <= '0;
    if (done_cnt > 0) done_cnt <= done_cnt - 1;
    if (cfu_en) begin
      if (cfu_cmd != 7'd0 && cfu_cmd != CMD_DONE) log_q.push_back({cfu_cmd, cfu_inp0, cfu_inp1});
      case (cfu_cmd)
        CMD_WR_FLT: for (int b = 0; b < 4; b++) fbuf[int'(cfu_inp0) + b] <= cfu_inp1[8*b +: 8];
        CMD_WR_IN:  for (int b = 0; b < 4; b++) ibuf[int'(cfu_inp0) + b] <= cfu_inp1[8*b +: 8];
        CMD_IN_OFF: r_in_off <= cfu_inp1;
        CMD_DEPTH:  r_depth <= cfu_inp1;
        CMD_BIAS, CMD_MULT, CMD_SHIFT, CMD_ACT_MIN, CMD_ACT_MAX, CMD_OUT_OFF:
          r_q[cfu_cmd - CMD_BIAS] <= cfu_inp1;
        CMD_START:  begin started <= 1'b1; done_cnt <= int'(r_depth); t6 <= cyc; end
        CMD_DONE:   cfu_ret <= {31'd0, started && done_cnt == 0 && !force_busy};
        CMD_GET_ACC: begin cfu_ret <= cfu_result(); t7 <= cyc; end
        default: ;
      endcase
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [70:0] obs, input logic [70:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0][31:0] mkq(input int bias, mult, shift, amin, amax, off);
    logic [5:0][31:0] q;
    q[0] = bias; q[1] = mult; q[2] = shift; q[3] = amin; q[4] = amax; q[5] = off;
    return q;
  endfunction

  task automatic feed(input logic [31:0] base, input logic [31:0] step, input int n, input bit tog);
    int sent = 0, c = 0;
    bit ph = 1'b1;
    while (sent < n && c < 4000) begin
      @(negedge clk);
      ld_valid = tog ? ph : 1'b1;
      ph = ~ph;
      ld_data = base + step * sent;
      if (ld_valid && ld_ready) sent++;
      c++;
    end
    @(negedge clk);
    ld_valid = 1'b0;
    chk("feed_words", 71'(sent), 71'(n));
  endtask

  task automatic launch(input int depth, input int in_off, input logic [5:0][31:0] q);
    @(negedge clk);
    log_q.delete();
    cfg_depth = depth; cfg_in_off = in_off; cfg_start_x = 32'd0; cfg_quant = q;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Runs one op to res_valid and checks the command log against the expected sequence.
  task automatic run_op(input int depth, input int in_off, input logic [5:0][31:0] q,
                        input logic [31:0] fb, input logic [31:0] fs,
                        input logic [31:0] ib, input logic [31:0] is, input bit tog);
    logic [70:0] exp_q[$];
    int c = 0;
    launch(depth, in_off, q);
    feed(fb, fs, 2 * depth, tog);
    feed(ib, is, 2 * depth, tog);
    while (!res_valid && c < 3000) begin @(negedge clk); c++; end
    chk("res_valid_seen", 71'(res_valid), 71'(1));
    exp_q.push_back({CMD_RW_WIDTH, 32'd0, 32'd4});
    exp_q.push_back({CMD_IN_OFF, 32'd0, 32'(in_off)});
    exp_q.push_back({CMD_DEPTH, 32'd0, 32'(depth)});
    exp_q.push_back({CMD_START_X, 32'd0, 32'd0});
    for (int i = 0; i < 6; i++) exp_q.push_back({CMD_BIAS + 7'(i), 32'd0, q[i]});
    for (int k = 0; k < 2 * depth; k++) exp_q.push_back({CMD_WR_FLT, 32'(4 * k), fb + fs * k});
    for (int k = 0; k < 2 * depth; k++) exp_q.push_back({CMD_WR_IN, 32'(4 * k), ib + is * k});
    exp_q.push_back({CMD_START, 32'd0, 32'd0});
    exp_q.push_back({CMD_GET_ACC, 32'd0, 32'd0});
    chk("log_len", 71'(log_q.size()), 71'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk($sformatf("log[%0d]", i), log_q[i], exp_q[i]);
  endtask

  task automatic drain();
    @(negedge clk);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("drain_res_valid", 71'(res_valid), 71'(0));
    chk("drain_busy", 71'(busy), 71'(0));
  endtask

  logic [5:0][31:0] unity;
  logic [31:0] held;

  initial begin
    unity = mkq(0, 1, 0, -128, 127, 0);

    // reset state
    rst = 1'b1;
    #1;
    chk("rst_busy", 71'(busy), 71'(0));
    chk("rst_outs", {res_valid, err, cfu_en, ld_ready, cfu_cmd, cfu_inp0, cfu_inp1}, 71'(0));
    chk("rst_res_data", 71'(res_data), 71'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // depth=1: filter 1, input 2 -> 16; also exercise a held result
    run_op(1, 0, unity, 32'h01010101, 32'd0, 32'h02020202, 32'd0, 1'b0);
    chk("d1_result", 71'(res_data), 71'(16));
    held = res_data;
    for (int i = 0; i < 10; i++) @(negedge clk);
    chk("hold_valid", 71'(res_valid), 71'(1));
    chk("hold_data", 71'(res_data), 71'(held));
    chk("hold_busy", 71'(busy), 71'(1));
    chk("hold_en_low", 71'(cfu_en), 71'(0));
    drain();

    // depth=2 with toggling ld_valid: filter bytes 1..4 per word, input 3, off 1 -> 84
    run_op(2, 1, mkq(5, 1, 1, -128, 127, 2), 32'h01010101, 32'h01010101, 32'h03030303, 32'd0, 1'b1);
    chk("d2_result", 71'(res_data), 71'(84));
    drain();

    // depth=0: no loads, done on first valid poll, result = quant(0) = (20*3)>>>2 - 5 = 10
    run_op(0, 0, mkq(20, 3, 2, -128, 127, -5), 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    chk("d0_result", 71'(res_data), 71'(10));
    chk("d0_poll_latency", 71'(t7 - t6), 71'(3));
    drain();

    // rejected start: depth 129
    @(negedge clk);
    log_q.delete();
    cfg_depth = 32'd129;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rej_err", 71'(err), 71'(1));
    chk("rej_busy", 71'(busy), 71'(0));
    @(negedge clk);
    chk("rej_err_pulse", 71'(err), 71'(0));
    chk("rej_idle_outs", {busy, cfu_en, cfu_cmd}, 71'(0));
    @(negedge clk);
    chk("rej_no_cmds", 71'(log_q.size()), 71'(0));

    // reset during LOAD_I, then full replay: 16 taps of 2*(-1+5) = 128 -> clamped to 127
    launch(2, 5, unity);
    feed(32'h01010101, 32'd0, 4, 1'b0);
    feed(32'h01010101, 32'd0, 1, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_outs", {busy, res_valid, err, cfu_en, ld_ready, cfu_cmd, cfu_inp0, cfu_inp1}, 71'(0));
    @(negedge clk);
    rst = 1'b0;
    run_op(2, 5, unity, 32'h02020202, 32'd0, 32'hFFFFFFFF, 32'd0, 1'b0);
    chk("replay_result", 71'(res_data), 71'(127));
    drain();

    // largest accepted depth: 1024 taps of 1*1, >>>4 -> 64
    run_op(128, 0, mkq(0, 1, 4, -128, 127, 0), 32'h01010101, 32'd0, 32'h01010101, 32'd0, 1'b0);
    chk("dmax_result", 71'(res_data), 71'(64));
    drain();

`ifdef CFU_SEQ_TIMEOUT_EN
    begin
      int c = 0;
      bit seen = 1'b0;
      force_busy = 1'b1;
      launch(0, 0, unity);
      while (!seen && c < 6000) begin @(negedge clk); seen = err; c++; end
      chk("tmo_err", 71'(seen), 71'(1));
      chk("tmo_res_valid", 71'(res_valid), 71'(0));
      chk("tmo_busy", 71'(busy), 71'(0));
      force_busy = 1'b0;
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
